// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB encodings, error FSM states and bridge region defaults
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef enum logic [1:0] {
    ERR_OKAY   = 2'b00,
    ERR_FIRST  = 2'b01,
    ERR_SECOND = 2'b10
  } err_state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] DEF_SLV_SIZE  = 32'h0400_0000;

endpackage

// File: rtl/ahb_addr_decode.sv
// rtl/ahb_addr_decode.sv - peripheral region decode producing valid and one-hot tempselx
module ahb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0] SLV_SIZE  = ADDR_W'(DEF_SLV_SIZE)
) (
  input  logic               hreadyin,
  input  logic [1:0]         htrans,
  input  logic [ADDR_W-1:0]  haddr,
  output logic               valid,
  output logic [NUM_SLV-1:0] tempselx
);

  // Extra headroom so region bounds past the top of the address space do not wrap.
  localparam int EW = ADDR_W + 16;

  // One comparison window per peripheral; outside every window no select is raised.
  always_comb begin
    logic [EW-1:0] lo;
    logic [EW-1:0] hi;
    lo       = '0;
    hi       = '0;
    tempselx = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      lo = EW'(BASE_ADDR) + EW'(k) * EW'(SLV_SIZE);
      hi = lo + EW'(SLV_SIZE);
      tempselx[k] = (EW'(haddr) >= lo) && (EW'(haddr) < hi);
    end
  end

  // htrans[1] is set exactly for NONSEQ and SEQ.
  always_comb begin
    valid = hreadyin && htrans[1] && (|tempselx);
  end

endmodule

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB slave front end of the AHB-to-APB bridge; AHB_SLV_ERRRESP_EN enables the error response FSM
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0] SLV_SIZE  = ADDR_W'(DEF_SLV_SIZE)
) (
  input  logic               clk,
  input  logic               hresetn,
  input  logic               hwrite,
  input  logic               hreadyin,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hsize,
  input  logic [2:0]         hburst,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic               hready_ctrl,
  output logic               valid,
  output logic [ADDR_W-1:0]  haddr1,
  output logic [ADDR_W-1:0]  haddr2,
  output logic [DATA_W-1:0]  hwdata1,
  output logic [DATA_W-1:0]  hwdata2,
  output logic               hwrite_reg,
  output logic               hwrite_reg1,
  output logic [NUM_SLV-1:0] tempselx,
  output logic [3:0]         beat_cnt,
  output logic               hresp,
  output logic               hreadyout
);

  // Size and burst type are forwarded by the master but the beat counter alone tracks bursts here.
  logic unused_ok;
  assign unused_ok = ^{hsize, hburst};

  ahb_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_SLV  (NUM_SLV),
    .BASE_ADDR(BASE_ADDR),
    .SLV_SIZE (SLV_SIZE)
  ) u_decode (
    .hreadyin(hreadyin),
    .htrans  (htrans),
    .haddr   (haddr),
    .valid   (valid),
    .tempselx(tempselx)
  );

  // Two-stage address/data/direction pipeline, frozen while the bus is not ready.
  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1      <= '0;
      haddr2      <= '0;
      hwdata1     <= '0;
      hwdata2     <= '0;
      hwrite_reg  <= 1'b0;
      hwrite_reg1 <= 1'b0;
    end else if (hreadyin) begin
      haddr1      <= haddr;
      haddr2      <= haddr1;
      hwdata1     <= hwdata;
      hwdata2     <= hwdata1;
      hwrite_reg  <= hwrite;
      hwrite_reg1 <= hwrite_reg;
    end
  end

  // Burst beat index: restart on an accepted NONSEQ, count accepted SEQ beats, stick at 15.
  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      beat_cnt <= 4'd0;
    end else if (valid) begin
      if (htrans == HTRANS_NONSEQ) begin
        beat_cnt <= 4'd0;
      end else if (beat_cnt != 4'hF) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

`ifdef AHB_SLV_ERRRESP_EN
  err_state_e err_state;
  logic       err_req;
  logic       err_hold;
  logic       err_ready;

  assign err_req   = hreadyin && htrans[1] && !(|tempselx);
  // err_hold overrides the controller's ready with the FSM's own two-cycle response.
  assign hreadyout = err_hold ? err_ready : hready_ctrl;

  // Two-cycle ERROR response; ERR_SECOND behaves like OKAY for sampling a new bad transfer.
  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      err_state <= ERR_OKAY;
      hresp     <= 1'b0;
      err_hold  <= 1'b1;
      err_ready <= 1'b1;
    end else begin
      case (err_state)
        ERR_FIRST: begin
          err_state <= ERR_SECOND;
          hresp     <= 1'b1;
          err_hold  <= 1'b1;
          err_ready <= 1'b1;
        end
        default: begin
          if (err_req) begin
            err_state <= ERR_FIRST;
            hresp     <= 1'b1;
            err_hold  <= 1'b1;
            err_ready <= 1'b0;
          end else begin
            err_state <= ERR_OKAY;
            hresp     <= 1'b0;
            err_hold  <= 1'b0;
            err_ready <= 1'b1;
          end
        end
      endcase
    end
  end
`else
  // Out-of-range transfers are dropped silently; the controller alone paces the bus.
  assign hresp     = 1'b0;
  assign hreadyout = hready_ctrl;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - self-checking bench for ahb_slave_if
module tb_ahb_slave_if;
  import ahb_apb_pkg::*;

  localparam longint unsigned BASE = 64'h8000_0000;
  localparam longint unsigned SIZE = 64'h0400_0000;
  localparam int              NS   = 3;

  logic        clk = 1'b0;
  logic        hresetn, hwrite, hreadyin, hready_ctrl;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [31:0] haddr, hwdata;
  logic        valid, hwrite_reg, hwrite_reg1, hresp, hreadyout;
  logic [31:0] haddr1, haddr2, hwdata1, hwdata2;
  logic [2:0]  tempselx;
  logic [3:0]  beat_cnt;

  always #5 clk = ~clk;

  ahb_slave_if #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(NS),
    .BASE_ADDR(32'h8000_0000), .SLV_SIZE(32'h0400_0000)
  ) dut (
    .clk(clk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
    .htrans(htrans), .hsize(hsize), .hburst(hburst), .haddr(haddr),
    .hwdata(hwdata), .hready_ctrl(hready_ctrl), .valid(valid),
    .haddr1(haddr1), .haddr2(haddr2), .hwdata1(hwdata1), .hwdata2(hwdata2),
    .hwrite_reg(hwrite_reg), .hwrite_reg1(hwrite_reg1), .tempselx(tempselx),
    .beat_cnt(beat_cnt), .hresp(hresp), .hreadyout(hreadyout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: delay line contents, burst index, error response phase.
  logic [31:0] m_a1, m_a2, m_d1, m_d2;
  logic        m_w1, m_w2;
  int          m_beat;
  int          m_eph;   // 0: none, 1: first error cycle, 2: second error cycle
  bit          m_rst;   // reset seen, no clock edge since

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (64'(a) >= BASE) && (64'(a) < BASE + 64'(NS) * SIZE);
  endfunction

  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    logic [63:0] idx;
    if (!in_rng(a)) return 3'b000;
    idx = (64'(a) - BASE) / SIZE;
    return 3'(64'd1 << idx);
  endfunction

  task automatic model_reset();
    m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
    m_w1 = 1'b0; m_w2 = 1'b0; m_beat = 0; m_eph = 0; m_rst = 1'b1;
  endtask

  task automatic model_update();
    bit legal;
    bit inr;
    legal = hreadyin && htrans[1];
    inr   = in_rng(haddr);
    if (hreadyin) begin
      m_a2 = m_a1; m_a1 = haddr;
      m_d2 = m_d1; m_d1 = hwdata;
      m_w2 = m_w1; m_w1 = hwrite;
    end
    if (legal && inr) m_beat = (htrans == 2'b10) ? 0 : ((m_beat < 15) ? m_beat + 1 : 15);
    if (m_eph == 1) m_eph = 2;
    else m_eph = (legal && !inr) ? 1 : 0;
    m_rst = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic exp_resp;
    logic exp_rdy;
`ifdef AHB_SLV_ERRRESP_EN
    exp_resp = (m_eph != 0);
    exp_rdy  = m_rst ? 1'b1 : (m_eph == 1) ? 1'b0 : (m_eph == 2) ? 1'b1 : hready_ctrl;
`else
    exp_resp = 1'b0;
    exp_rdy  = hready_ctrl;
`endif
    chk({tag, ":valid"},    valid,    hreadyin && htrans[1] && in_rng(haddr));
    chk({tag, ":tempselx"}, tempselx, exp_sel(haddr));
    chk({tag, ":haddr1"},   haddr1,   m_a1);
    chk({tag, ":haddr2"},   haddr2,   m_a2);
    chk({tag, ":hwdata1"},  hwdata1,  m_d1);
    chk({tag, ":hwdata2"},  hwdata2,  m_d2);
    chk({tag, ":hwrite1"},  hwrite_reg,  m_w1);
    chk({tag, ":hwrite2"},  hwrite_reg1, m_w2);
    chk({tag, ":beat_cnt"}, beat_cnt, m_beat);
    chk({tag, ":hresp"},    hresp,    exp_resp);
    chk({tag, ":hreadyout"}, hreadyout, exp_rdy);
  endtask

  // Apply one cycle of inputs (called at a falling edge), check, clock, advance the model.
  task automatic step(input string tag, input logic [1:0] tr, input logic wr, input logic rdy,
                      input logic [31:0] a, input logic [31:0] d, input logic rc);
    htrans = tr; hwrite = wr; hreadyin = rdy; haddr = a; hwdata = d; hready_ctrl = rc;
    #2;
    check_all(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic pulse_reset(input string tag);
    #1 hresetn = 1'b0;
    #1;
    model_reset();
    chk({tag, ":rst_haddr1"},  haddr1, 0);
    chk({tag, ":rst_haddr2"},  haddr2, 0);
    chk({tag, ":rst_hwdata1"}, hwdata1, 0);
    chk({tag, ":rst_beat"},    beat_cnt, 0);
    chk({tag, ":rst_hresp"},   hresp, 0);
    check_all({tag, ":rst"});
    @(negedge clk);
    hresetn = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  tr;
    logic        rdy;
    logic [31:0] a;
    logic        ev;
    logic [2:0]  es;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] bnd[8];
  logic [31:0] ra;

  initial begin
    vecs.push_back('{2'b10, 1'b1, 32'h8000_0000, 1'b1, 3'b001});
    vecs.push_back('{2'b11, 1'b1, 32'h83FF_FFFF, 1'b1, 3'b001});
    vecs.push_back('{2'b10, 1'b1, 32'h8400_0000, 1'b1, 3'b010});
    vecs.push_back('{2'b10, 1'b1, 32'h8800_0000, 1'b1, 3'b100});
    vecs.push_back('{2'b11, 1'b1, 32'h8BFF_FFFF, 1'b1, 3'b100});
    vecs.push_back('{2'b10, 1'b1, 32'h8C00_0000, 1'b0, 3'b000});
    vecs.push_back('{2'b10, 1'b1, 32'h7FFF_FFFF, 1'b0, 3'b000});
    vecs.push_back('{2'b00, 1'b1, 32'h8000_0010, 1'b0, 3'b001});
    vecs.push_back('{2'b01, 1'b1, 32'h8400_0010, 1'b0, 3'b010});
    vecs.push_back('{2'b11, 1'b0, 32'h8800_0010, 1'b0, 3'b100});
    bnd = '{32'h7FFF_FFFC, 32'h8000_0000, 32'h83FF_FFFC, 32'h8400_0000,
            32'h87FF_FFFC, 32'h8800_0000, 32'h8BFF_FFFC, 32'h8C00_0000};

    hresetn = 1'b0; htrans = 2'b00; hwrite = 1'b0; hreadyin = 1'b1;
    haddr = '0; hwdata = '0; hready_ctrl = 1'b1; hsize = HSIZE_WORD; hburst = HBURST_INCR4;
    model_reset();
    #2;
    chk("reset:hreadyout", hreadyout, 1);
    check_all("reset");
    @(negedge clk);
    hresetn = 1'b1;

    // Single write, then its data phase
    step("wr_a", 2'b10, 1'b1, 1'b1, 32'h8000_0001, 32'h0, 1'b1);
    chk("wr:valid", valid, 1);
    chk("wr:tempselx", tempselx, 3'b001);
    step("wr_d", 2'b00, 1'b0, 1'b1, 32'h0, 32'hA300_1111, 1'b1);
    chk("wr:hwdata1", hwdata1, 32'hA300_1111);

    // Single read
    step("rd_a", 2'b10, 1'b0, 1'b1, 32'h8000_00A2, 32'h0, 1'b1);
    chk("rd:valid", valid, 1);
    chk("rd:hwrite_reg", hwrite_reg, 0);
    step("rd_d", 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    chk("rd:haddr2", haddr2, 32'h8000_00A2);

    // INCR4 read
    for (int i = 0; i < 4; i++) begin
      step("incr4", (i == 0) ? 2'b10 : 2'b11, 1'b0, 1'b1, 32'h8000_00C0 + 32'(4 * i), 32'h0, 1'b1);
      chk("incr4:valid", valid, 1);
      chk("incr4:beat", beat_cnt, i);
    end

    // Out-of-range transfer and the error response that follows
    step("err_a", 2'b10, 1'b0, 1'b1, 32'h9000_0000, 32'h0, 1'b1);
    chk("err:valid", valid, 0);
    chk("err:tempselx", tempselx, 3'b000);
`ifdef AHB_SLV_ERRRESP_EN
    chk("err1:hresp", hresp, 1);     chk("err1:hreadyout", hreadyout, 0);
    step("err_1", 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("err2:hresp", hresp, 1);     chk("err2:hreadyout", hreadyout, 1);
    step("err_2", 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    chk("errok:hresp", hresp, 0);    chk("errok:hreadyout", hreadyout, 1);
`else
    chk("noerr1:hresp", hresp, 0);   chk("noerr1:hreadyout", hreadyout, 1);
    step("err_1", 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    chk("noerr2:hresp", hresp, 0);
`endif
    step("err_3", 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);

    // Stall mid-INCR4, then reset mid-burst
    step("st0", 2'b10, 1'b0, 1'b1, 32'h8000_00C0, 32'h0, 1'b1);
    step("st1", 2'b11, 1'b0, 1'b1, 32'h8000_00C4, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("stall", 2'b11, 1'b0, 1'b0, 32'h8000_00C8, 32'h0, 1'b1);
      chk("stall:haddr1", haddr1, 32'h8000_00C4);
      chk("stall:haddr2", haddr2, 32'h8000_00C0);
      chk("stall:beat", beat_cnt, 1);
    end
    step("st2", 2'b11, 1'b0, 1'b1, 32'h8000_00C8, 32'h0, 1'b1);
    chk("resume:beat", beat_cnt, 2);
    htrans = 2'b11; haddr = 32'h8000_00CC;
    pulse_reset("midburst");
    step("fresh", 2'b10, 1'b1, 1'b1, 32'h8400_0010, 32'h5, 1'b1);
    chk("fresh:beat", beat_cnt, 0);
    chk("fresh:tempselx", tempselx, 3'b010);

    // Table of decode boundaries and transfer types
    foreach (vecs[i]) begin
      step("tbl", vecs[i].tr, 1'b0, vecs[i].rdy, vecs[i].a, 32'(i), 1'b1);
      chk($sformatf("tbl%0d:valid", i), valid, vecs[i].ev);
      chk($sformatf("tbl%0d:tempselx", i), tempselx, vecs[i].es);
    end

    // Randomized traffic against the model
    ra = 32'h8000_0000;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'(BASE + 64'($urandom_range(0, 32'h0BFF_FFFF)));
        1: ra = bnd[$urandom_range(0, 7)];
        2: ra = $urandom;
        default: ra = ra + 32'd4;
      endcase
      if ($urandom_range(0, 79) == 0) pulse_reset("rnd");
      step("rnd", 2'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) != 0),
           ra, $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
